// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex display driver with frame-synchronous update.
// Optional blink support: define SEG_BLINK_EN.
module seg_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 1000
`ifdef SEG_BLINK_EN
   ,
   parameter int BLINK_FRAMES = 64
`endif
) (
   input  logic                      clk,
   input  logic                      clrn,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   data_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic                      en,
   input  logic                      lzb,
`ifdef SEG_BLINK_EN
   input  logic [NUM_DIGITS-1:0]     blink_mask,
`endif
   output logic [6:0]                seg_n,
   output logic                      dp_n,
   output logic [NUM_DIGITS-1:0]     dig_n,
   output logic                      frame_done
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]           r_presc;
   logic [IW-1:0]           r_idx;
   logic [4*NUM_DIGITS-1:0] r_shd_data;
   logic [NUM_DIGITS-1:0]   r_shd_dp;
   logic [4*NUM_DIGITS-1:0] r_dsp_data;
   logic [NUM_DIGITS-1:0]   r_dsp_dp;
   logic                    r_pend;

   logic                    w_tick;
   logic                    w_wrap;
   logic [3:0]              w_cur;
   logic                    w_blank;
   logic                    w_zero;
   logic                    w_dark;
   logic [6:0]              w_seg;
   logic                    w_dpn;
   logic [NUM_DIGITS-1:0]   w_dign;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      logic [6:0] s;
      unique case (h)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign w_tick = (r_presc == P_LAST);
   assign w_wrap = w_tick && (r_idx == I_LAST);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_presc    <= '0;
         r_idx      <= '0;
         frame_done <= 1'b0;
      end else begin
         r_presc    <= w_tick ? '0 : r_presc + PW'(1);
         frame_done <= w_wrap;
         if (w_tick)
            r_idx <= (r_idx == I_LAST) ? '0 : r_idx + IW'(1);
      end
   end

   // A load landing on the wrap tick bypasses the shadow entirely.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_shd_data <= '0;
         r_shd_dp   <= '0;
         r_dsp_data <= '0;
         r_dsp_dp   <= '0;
         r_pend     <= 1'b0;
      end else if (w_wrap && load) begin
         r_dsp_data <= data_in;
         r_dsp_dp   <= dp_in;
         r_pend     <= 1'b0;
      end else if (w_wrap && r_pend) begin
         r_dsp_data <= r_shd_data;
         r_dsp_dp   <= r_shd_dp;
         r_pend     <= 1'b0;
      end else if (load) begin
         r_shd_data <= data_in;
         r_shd_dp   <= dp_in;
         r_pend     <= 1'b1;
      end
   end

`ifdef SEG_BLINK_EN
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);
   logic [BW-1:0] r_bcnt;
   logic          r_bphase;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_bcnt   <= '0;
         r_bphase <= 1'b0;
      end else if (w_wrap) begin
         if (r_bcnt == B_LAST) begin
            r_bcnt   <= '0;
            r_bphase <= ~r_bphase;
         end else begin
            r_bcnt <= r_bcnt + BW'(1);
         end
      end
   end

   assign w_dark = r_bphase && blink_mask[r_idx];
`else
   assign w_dark = 1'b0;
`endif

   assign w_cur = r_dsp_data[4*r_idx +: 4];

   // Blank slot i when it and every more-significant digit are zero.
   always_comb begin
      w_blank = 1'b0;
      w_zero  = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         w_zero = w_zero && (r_dsp_data[4*i +: 4] == 4'h0);
         if (r_idx == IW'(i))
            w_blank = w_zero;
      end
   end

   always_comb begin
      w_seg  = hex7(w_cur);
      w_dpn  = ~r_dsp_dp[r_idx];
      w_dign = ~(NUM_DIGITS'(1) << r_idx);
      if (lzb && w_blank)
         w_seg = 7'h7F;
      if (w_dark) begin
         w_seg = 7'h7F;
         w_dpn = 1'b1;
      end
      if (!en) begin
         w_seg  = 7'h7F;
         w_dpn  = 1'b1;
         w_dign = '1;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         seg_n <= 7'h7F;
         dp_n  <= 1'b1;
         dig_n <= '1;
      end else begin
         seg_n <= w_seg;
         dp_n  <= w_dpn;
         dig_n <= w_dign;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver, NUM_DIGITS=4, SCAN_DIV=4.
// Edge k counts posedges since reset release; slot shown = ((k-1)/4)%4.
module tb_seg_scan_driver;

   logic        clk = 1'b0;
   logic        clrn = 1'b0;
   logic        load = 1'b0;
   logic [15:0] data_in = '0;
   logic [3:0]  dp_in = '0;
   logic        en = 1'b1;
   logic        lzb = 1'b0;
`ifdef SEG_BLINK_EN
   logic [3:0]  blink_mask = '0;
`endif
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [3:0]  dig_n;
   logic        frame_done;

   int n_chk = 0;
   int n_err = 0;
   int k = 0;

   seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
      .clk(clk), .clrn(clrn), .load(load),
      .data_in(data_in), .dp_in(dp_in),
      .en(en), .lzb(lzb),
`ifdef SEG_BLINK_EN
      .blink_mask(blink_mask),
`endif
      .seg_n(seg_n), .dp_n(dp_n),
      .dig_n(dig_n), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic at(input int kk);
      while (k < kk) begin
         @(posedge clk);
         k++;
      end
      #1;
   endtask

   task automatic slot(input string tag, input logic [3:0] dg,
                       input logic [6:0] sg, input logic dp);
      chk({tag, ".dig"}, 32'(dig_n), 32'(dg));
      chk({tag, ".seg"}, 32'(seg_n), 32'(sg));
      chk({tag, ".dp"},  32'(dp_n),  32'(dp));
   endtask

   task automatic do_load(input int kk, input logic [15:0] d,
                          input logic [3:0] p);
      at(kk - 1);
      load = 1'b1;
      data_in = d;
      dp_in = p;
      at(kk);
      load = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      slot("rst", 4'hF, 7'h7F, 1'b1);
      chk("rst.fd", 32'(frame_done), 32'h0);
      clrn = 1'b1;
      k = 0;

      do_load(1, 16'hFEDC, 4'b0100);
      slot("k1", 4'hE, 7'h40, 1'b1);
      at(15);
      chk("fd15", 32'(frame_done), 32'h0);
      at(16);
      chk("fd16", 32'(frame_done), 32'h1);
      slot("k16", 4'h7, 7'h40, 1'b1);
      at(17);
      chk("fd17", 32'(frame_done), 32'h0);
      slot("k17", 4'hE, 7'h46, 1'b1);
      at(21);
      slot("k21", 4'hD, 7'h21, 1'b1);
      at(25);
      slot("k25", 4'hB, 7'h06, 1'b0);
      at(29);
      slot("k29", 4'h7, 7'h0E, 1'b1);
      at(32);
      chk("fd32", 32'(frame_done), 32'h1);

      do_load(38, 16'h1234, 4'b0001);
      at(41);
      slot("k41", 4'hB, 7'h06, 1'b0);
      do_load(42, 16'h5678, 4'b0000);
      at(45);
      slot("k45", 4'h7, 7'h0E, 1'b1);
      at(49);
      slot("k49", 4'hE, 7'h00, 1'b1);
      at(53);
      slot("k53", 4'hD, 7'h78, 1'b1);
      at(57);
      slot("k57", 4'hB, 7'h02, 1'b1);
      at(61);
      slot("k61", 4'h7, 7'h12, 1'b1);

      lzb = 1'b1;
      do_load(62, 16'h0050, 4'b0000);
      at(65);
      slot("lz65", 4'hE, 7'h40, 1'b1);
      at(69);
      slot("lz69", 4'hD, 7'h12, 1'b1);
      at(73);
      slot("lz73", 4'hB, 7'h7F, 1'b1);
      at(77);
      slot("lz77", 4'h7, 7'h7F, 1'b1);
      lzb = 1'b0;
      at(78);
      slot("lz78", 4'h7, 7'h40, 1'b1);
      lzb = 1'b1;
      do_load(79, 16'h0000, 4'b0100);
      at(81);
      slot("z81", 4'hE, 7'h40, 1'b1);
      at(85);
      slot("z85", 4'hD, 7'h7F, 1'b1);
      at(89);
      slot("z89", 4'hB, 7'h7F, 1'b0);
      at(93);
      slot("z93", 4'h7, 7'h7F, 1'b1);

      at(96);
      en = 1'b0;
      at(97);
      slot("en97", 4'hF, 7'h7F, 1'b1);
      do_load(100, 16'h9ABC, 4'b1000);
      at(105);
      slot("en105", 4'hF, 7'h7F, 1'b1);
      at(112);
      chk("en.fd112", 32'(frame_done), 32'h1);
      at(128);
      chk("en.fd128", 32'(frame_done), 32'h1);
      slot("en128", 4'hF, 7'h7F, 1'b1);
      en = 1'b1;
      at(129);
      slot("en129", 4'hE, 7'h46, 1'b1);
      at(141);
      slot("en141", 4'h7, 7'h10, 1'b0);

      lzb = 1'b0;
      do_load(142, 16'h1111, 4'b1111);
      at(143);
      clrn = 1'b0;
      #1;
      slot("mrst", 4'hF, 7'h7F, 1'b1);
      chk("mrst.fd", 32'(frame_done), 32'h0);
      @(posedge clk);
      #1;
      slot("mrst.hold", 4'hF, 7'h7F, 1'b1);
      clrn = 1'b1;
      k = 0;
      at(1);
      slot("r1", 4'hE, 7'h40, 1'b1);
      at(4);
      slot("r4", 4'hE, 7'h40, 1'b1);
      at(5);
      slot("r5", 4'hD, 7'h40, 1'b1);
      at(16);
      chk("r.fd16", 32'(frame_done), 32'h1);
      at(17);
      slot("r17", 4'hE, 7'h40, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
